// File: rtl/mod_reduce_128_if.sv
// Stream bundle between mod_reduce_128 and its neighbours: product in, remainder out.
// The master side supplies the product/modulus and consumes the remainder.
interface mod_reduce_128_if #(
  parameter int WIDTH = 64
);
  logic [2*WIDTH-1:0] input_tdata;
  logic               input_tvalid;
  logic               input_tready;
  logic [WIDTH-1:0]   modulus;
  logic [WIDTH-1:0]   output_tdata;
  logic               output_tvalid;
  logic               output_tready;
  logic               output_error;

  modport master (
    output input_tdata,
    output input_tvalid,
    input  input_tready,
    output modulus,
    input  output_tdata,
    input  output_tvalid,
    output output_tready,
    input  output_error
  );

  modport slave (
    input  input_tdata,
    input  input_tvalid,
    output input_tready,
    input  modulus,
    output output_tdata,
    output output_tvalid,
    input  output_tready,
    output output_error
  );
endinterface

// File: rtl/mod_reduce_128.sv
// Bit-serial restoring reduction of a 2*WIDTH-bit product modulo a WIDTH-bit modulus.
// Optional MOD_REDUCE_128_FAST_PATH_EN: products already below the modulus finish in one cycle.
module mod_reduce_128 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  mod_reduce_128_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(PW) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(PW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;

  logic               accept;
  logic               fast_hit;
  logic [WIDTH-1:0]   step_r;

  // One restoring step: shift the next product bit into r and subtract m if it fits.
  // Since r < m, t < 2m, so the result always fits back into WIDTH bits.
  function automatic logic [WIDTH-1:0] restore_step(
    input logic [WIDTH-1:0] r,
    input logic             bit_in,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;
    t    = {r, bit_in};
    diff = t - {1'b0, m};
    if (t >= {1'b0, m}) restore_step = diff[WIDTH-1:0];
    else                restore_step = t[WIDTH-1:0];
  endfunction

  assign bus.input_tready = (state_q == IDLE) && !rst;
  assign accept           = bus.input_tvalid && bus.input_tready;
  assign step_r           = restore_step(r_q, q_q[PW-1], m_q);

`ifdef MOD_REDUCE_128_FAST_PATH_EN
  assign fast_hit = (bus.input_tdata[PW-1:WIDTH] == '0) &&
                    (bus.input_tdata[WIDTH-1:0] < bus.modulus) &&
                    (bus.modulus != '0);
`else
  assign fast_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = vld_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          q_d   = bus.input_tdata;
          m_d   = bus.modulus;
          r_d   = '0;
          cnt_d = '0;
          if (bus.modulus == '0) begin
            state_d = DONE;
            out_d   = '0;
            err_d   = 1'b1;
            vld_d   = 1'b1;
          end else if (fast_hit) begin
            state_d = DONE;
            out_d   = bus.input_tdata[WIDTH-1:0];
            err_d   = 1'b0;
            vld_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        q_d   = q_q << 1;
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          out_d   = step_r;
          vld_d   = 1'b1;
        end
      end

      DONE: begin
        // out_q is deliberately kept after the handshake; only valid/error drop.
        if (bus.output_tready) begin
          vld_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      m_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      m_q   <= m_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  assign bus.output_tdata  = out_q;
  assign bus.output_tvalid = vld_q;
  assign bus.output_error  = err_q;

endmodule

// File: tb/tb_mod_reduce_128.sv
// Randomised self-checking bench for mod_reduce_128 against a plain-arithmetic reference.
module tb_mod_reduce_128;

  localparam int WIDTH    = 64;
  localparam int PW       = 2 * WIDTH;
  localparam int FULL_LAT = PW + 1;
  localparam int BOUND    = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_reduce_128_if #(.WIDTH(WIDTH)) bus ();

  mod_reduce_128 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [WIDTH-1:0] ref_mod(input logic [PW-1:0] p, input logic [WIDTH-1:0] m);
    logic [PW-1:0] wide;
    if (m == '0) return '0;
    wide = p % {{WIDTH{1'b0}}, m};
    return wide[WIDTH-1:0];
  endfunction

  function automatic int ref_lat(input logic [PW-1:0] p, input logic [WIDTH-1:0] m);
    if (m == '0) return 1;
`ifdef MOD_REDUCE_128_FAST_PATH_EN
    if (p < {{WIDTH{1'b0}}, m}) return 1;
`else
    if (p == '1) return FULL_LAT; // keeps p referenced in both builds
`endif
    return FULL_LAT;
  endfunction

  function automatic logic [PW-1:0] rand_prod();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Present one product, wait for acceptance, then scramble the inputs.
  task automatic accept_product(input logic [PW-1:0] p, input logic [WIDTH-1:0] m,
                                output int waited, output bit to);
    waited = 0;
    to     = 1'b0;
    @(negedge clk);
    while (bus.input_tready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > BOUND) begin
        to = 1'b1;
        return;
      end
    end
    bus.input_tdata  = p;
    bus.modulus      = m;
    bus.input_tvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.input_tvalid = 1'b0;
    bus.input_tdata  = rand_prod();
    bus.modulus      = rand_word();
  endtask

  // Count negedges until output_tvalid; also note whether input_tready ever rose meanwhile.
  task automatic wait_valid(output int lat, output bit rdy_low, output bit to);
    lat     = 0;
    rdy_low = 1'b1;
    to      = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.input_tready !== 1'b0) rdy_low = 1'b0;
      if (bus.output_tvalid === 1'b1) break;
      if (lat > BOUND) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_output();
    bus.output_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.output_tready = 1'b0;
  endtask

  task automatic transact(input logic [PW-1:0] p, input logic [WIDTH-1:0] m,
                          output int waited, output int lat, output bit rdy_low, output bit to);
    bit to_a, to_v;
    accept_product(p, m, waited, to_a);
    if (to_a) begin
      lat = 0; rdy_low = 1'b0; to = 1'b1;
      return;
    end
    wait_valid(lat, rdy_low, to_v);
    to = to_v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (bus.output_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", bus.output_tdata); end
    checks++; if (bus.output_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", bus.output_tvalid); end
    checks++; if (bus.output_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", bus.output_error); end
    checks++; if (bus.input_tready !== 1'b0) begin failures++; $display("FAIL reset_tready_in_rst got=%b exp=0", bus.input_tready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.input_tready !== 1'b1) begin failures++; $display("FAIL reset_tready_after got=%b exp=1", bus.input_tready); end
  endtask

  task automatic test_basic();
    int w, lat; bit rl, to;
    transact(128'd100, 64'd7, w, lat, rl, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=valid"); end
    checks++; if (bus.output_tdata !== 64'd2) begin failures++; $display("FAIL basic_data got=%0d exp=2", bus.output_tdata); end
    checks++; if (bus.output_error !== 1'b0) begin failures++; $display("FAIL basic_error got=%b exp=0", bus.output_error); end
    checks++; if (lat != FULL_LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, FULL_LAT); end
    checks++; if (!rl) begin failures++; $display("FAIL basic_tready_busy got=high exp=low"); end
    release_output();
    @(negedge clk);
    checks++; if (bus.output_tvalid !== 1'b0) begin failures++; $display("FAIL basic_valid_clear got=%b exp=0", bus.output_tvalid); end
    checks++; if (bus.input_tready !== 1'b1) begin failures++; $display("FAIL basic_tready_idle got=%b exp=1", bus.input_tready); end
    checks++; if (bus.output_tdata !== 64'd2) begin failures++; $display("FAIL basic_data_kept got=%0d exp=2", bus.output_tdata); end
  endtask

  task automatic test_back_to_back();
    int w, lat; bit rl, to;
    logic [PW-1:0] p2;
    transact('1, '1, w, lat, rl, to);
    checks++; if (to || bus.output_tdata !== '0) begin failures++; $display("FAIL b2b_first got=%h exp=0", bus.output_tdata); end
    checks++; if (!rl) begin failures++; $display("FAIL b2b_first_tready got=high exp=low"); end
    release_output();
    p2 = '0;
    p2[WIDTH] = 1'b1;
    transact(p2, '1, w, lat, rl, to);
    checks++; if (w != 0) begin failures++; $display("FAIL b2b_accept_delay got=%0d exp=0", w); end
    checks++; if (to || bus.output_tdata !== 64'd1) begin failures++; $display("FAIL b2b_second got=%h exp=1", bus.output_tdata); end
    checks++; if (lat != FULL_LAT) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, FULL_LAT); end
    checks++; if (!rl) begin failures++; $display("FAIL b2b_second_tready got=high exp=low"); end
    release_output();
  endtask

  task automatic test_zero_modulus();
    int w, lat; bit rl, to;
    transact(rand_prod(), '0, w, lat, rl, to);
    checks++; if (to || bus.output_tdata !== '0) begin failures++; $display("FAIL zmod_data got=%h exp=0", bus.output_tdata); end
    checks++; if (bus.output_error !== 1'b1) begin failures++; $display("FAIL zmod_error got=%b exp=1", bus.output_error); end
    checks++; if (lat != 1) begin failures++; $display("FAIL zmod_latency got=%0d exp=1", lat); end
    release_output();
    @(negedge clk);
    checks++; if (bus.output_error !== 1'b0) begin failures++; $display("FAIL zmod_error_clear got=%b exp=0", bus.output_error); end
    checks++; if (bus.output_tvalid !== 1'b0) begin failures++; $display("FAIL zmod_valid_clear got=%b exp=0", bus.output_tvalid); end
  endtask

  task automatic test_fast_path();
    int w, lat, exp_lat; bit rl, to;
    exp_lat = ref_lat(128'd5, 64'd9);
    transact(128'd5, 64'd9, w, lat, rl, to);
    checks++; if (to || bus.output_tdata !== 64'd5) begin failures++; $display("FAIL fast_data got=%0d exp=5", bus.output_tdata); end
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL fast_latency got=%0d exp=%0d", lat, exp_lat); end
    checks++; if (bus.output_error !== 1'b0) begin failures++; $display("FAIL fast_error got=%b exp=0", bus.output_error); end
    release_output();
  endtask

  task automatic test_backpressure();
    int w, lat; bit rl, to, stable, rdy_low;
    logic [PW-1:0] p;
    logic [WIDTH-1:0] m, exp;
    p   = rand_prod();
    m   = rand_word() | 64'h8000_0000_0000_0000;
    exp = ref_mod(p, m);
    transact(p, m, w, lat, rl, to);
    checks++; if (to || bus.output_tdata !== exp) begin failures++; $display("FAIL bp_data got=%h exp=%h", bus.output_tdata, exp); end
    stable  = 1'b1;
    rdy_low = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.output_tvalid !== 1'b1 || bus.output_tdata !== exp) stable = 1'b0;
      if (bus.input_tready !== 1'b0) rdy_low = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("FAIL bp_stable got=changed exp=held"); end
    checks++; if (!rdy_low) begin failures++; $display("FAIL bp_tready got=high exp=low"); end
    release_output();
    @(negedge clk);
    checks++; if (bus.output_tvalid !== 1'b0) begin failures++; $display("FAIL bp_one_transfer got=%b exp=0", bus.output_tvalid); end
    checks++; if (bus.input_tready !== 1'b1) begin failures++; $display("FAIL bp_tready_after got=%b exp=1", bus.input_tready); end
  endtask

  task automatic test_reset_mid_run();
    int w, lat; bit rl, to, to_a, spurious;
    accept_product(128'd100, 64'd7, w, to_a);
    checks++; if (to_a) begin failures++; $display("FAIL rmid_accept got=timeout exp=accepted"); end
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.output_tdata !== '0) begin failures++; $display("FAIL rmid_tdata got=%h exp=0", bus.output_tdata); end
    checks++; if (bus.output_tvalid !== 1'b0) begin failures++; $display("FAIL rmid_tvalid got=%b exp=0", bus.output_tvalid); end
    checks++; if (bus.input_tready !== 1'b0) begin failures++; $display("FAIL rmid_tready got=%b exp=0", bus.input_tready); end
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (FULL_LAT + 10) begin
      @(negedge clk);
      if (bus.output_tvalid !== 1'b0) spurious = 1'b1;
    end
    checks++; if (spurious) begin failures++; $display("FAIL rmid_no_output got=valid exp=none"); end
    transact(128'd100, 64'd7, w, lat, rl, to);
    checks++; if (to || bus.output_tdata !== 64'd2) begin failures++; $display("FAIL rmid_recover got=%0d exp=2", bus.output_tdata); end
    checks++; if (lat != FULL_LAT) begin failures++; $display("FAIL rmid_latency got=%0d exp=%0d", lat, FULL_LAT); end
    release_output();
  endtask

  task automatic test_random();
    int w, lat, exp_lat; bit rl, to;
    logic [PW-1:0] p;
    logic [WIDTH-1:0] m, exp;
    for (int i = 0; i < 40; i++) begin
      case (i % 5)
        0: begin p = rand_prod(); m = rand_word(); end
        1: begin p = rand_prod(); m = WIDTH'($urandom_range(1, 1000)); end
        2: begin m = rand_word() | 64'd2; p = {{WIDTH{1'b0}}, rand_word() % m}; end
        3: begin p = rand_prod(); m = (i % 10 == 3) ? '0 : rand_word(); end
        default: begin p = {{WIDTH{1'b0}}, rand_word()}; m = rand_word(); end
      endcase
      exp     = ref_mod(p, m);
      exp_lat = ref_lat(p, m);
      transact(p, m, w, lat, rl, to);
      checks++;
      if (to || bus.output_tdata !== exp || bus.output_error !== (m == '0) || lat != exp_lat || !rl) begin
        failures++;
        $display("FAIL rand_%0d p=%h m=%h got=%h err=%b lat=%0d exp=%h err=%b lat=%0d",
                 i, p, m, bus.output_tdata, bus.output_error, lat, exp, (m == '0), exp_lat);
      end
      release_output();
    end
  endtask

  initial begin
    bus.input_tdata   = '0;
    bus.input_tvalid  = 1'b0;
    bus.modulus       = '0;
    bus.output_tready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_modulus();
    test_fast_path();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
